fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 32-bit pipelined RISC-V core. It sits directly upstream of the instruction memory: it owns the program counter and drives the memory's byte address. The memory returns the instruction combinationally in the same cycle, and this stage captures it into the IF/ID pipeline register. It handles stall, flush/redirect from EX, an EBREAK halt state, a fetch counter and optional JAL predecode.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INST, 32'h0000_0013, instruction injected into IF/ID on bubbles (addi x0,x0,0)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  hazard unit hold: PC and IF/ID keep their values
- redirect_valid  input  1  EX-stage taken branch/jump or flush
- redirect_target  input  32  new PC when redirect_valid=1
- resume  input  1  leave HALT state and continue at current PC
- inst_in  input  32  instruction word from instruction memory
- instruct_address_out  output  32  byte address to instruction memory (= pc)
- if_id_pc  output  32  PC of the instruction held in IF/ID
- if_id_inst  output  32  instruction held in IF/ID
- if_id_valid  output  1  IF/ID holds a real instruction
- if_id_pred_taken  output  1  fetch already redirected on this JAL
- halted  output  1  stage is in HALT
- fetch_count  output  32  number of valid instructions written into IF/ID

## Operation
- FSM states: RUN, HALT. Reset enters RUN.
- Each rising edge in RUN evaluates the following in priority order:
  - **redirect_valid=1**:
    - pc <= {redirect_target[31:2],2'b00}; target bits [1:0] are ignored.
    - IF/ID <= {pc, NOP_INST, valid=0, pred=0}.
    - Applies even when stall=1.
  - **stall=1**: pc, IF/ID and fetch_count hold.
  - **inst_in = 32'h0010_0073 (EBREAK)**:
    - IF/ID <= {pc, inst_in, valid=1}, then the FSM enters HALT.
    - pc <= pc+4.
  - **otherwise**:
    - IF/ID <= {pc, inst_in, valid=1}.
    - pc <= pc+4 (or the JAL target, see Configuration).
- fetch_count increments by 1 on every edge that writes valid=1. It wraps at 2^32.
- In HALT:
  - pc holds; IF/ID <= NOP bubble (valid=0).
  - resume=1 returns the FSM to RUN on the next edge.
  - redirect_valid=1 also returns the FSM to RUN and loads the target. It takes priority over resume.
- Arithmetic is 32-bit modulo: pc 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- instruct_address_out is combinational from the pc register; there is no memory-read cycle of latency.
- Fetch-to-IF/ID latency is 1 cycle: the instruction at pc appears on if_id_* after the next rising edge.
- Redirect penalty is 1 bubble: the target instruction is in IF/ID 2 edges after redirect_valid is sampled.
- Reset values (asynchronous, immediate on rst_n=0):
  - pc = RESET_PC; state = RUN; fetch_count = 0; halted = 0.
  - if_id_pc = RESET_PC, if_id_inst = NOP_INST, if_id_valid = 0, if_id_pred_taken = 0.
- Reset asserted mid-stall, mid-redirect or in HALT discards all state.
- The first valid IF/ID entry after rst_n rises appears 1 edge later.
- halted is registered; it is high from the edge that enters HALT until the edge that leaves it.

## Configuration
- JAL_PREDECODE_EN defined:
  - In RUN, not stalled, no redirect, and inst_in[6:0]=7'b1101111 (JAL): pc <= pc + imm_j, and if_id_pred_taken <= 1.
  - imm_j = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}.
  - The JAL itself still enters IF/ID with valid=1, so the link register is written downstream.
  - EX must not re-redirect a JAL marked pred_taken.
- JAL_PREDECODE_EN undefined:
  - JAL is treated as an ordinary instruction: pc <= pc+4, and if_id_pred_taken is tied to 0.
  - EX redirects as normal.

## Test plan
- Reset then free-run with inst_in = addi words: addresses 0x00, 0x04, 0x08 are issued; if_id_pc follows one cycle later; fetch_count=3 after 3 edges.
- stall high 2 cycles at pc=0x10: pc and if_id hold for 2 edges. redirect_valid with target 0x23 during the stall: pc=0x20, one NOP bubble (valid=0), then if_id_pc=0x20.
- EBREAK (0x00100073) at pc=0x30: IF/ID valid=1 with the EBREAK; halted=1; bubbles while pc holds at 0x34. resume=1 on its next edge: if_id_pc=0x34.
- pc=0xFFFFFFFC with a non-control instruction: next pc=0x00000000. rst_n pulsed low mid-HALT: all outputs at reset values immediately.
- JAL_PREDECODE_EN defined, covering backward and forward JAL targets:
  - pc=0x1C, inst_in=0x00C0006F: next pc=0x28, pred_taken=1, no bubble.
  - pc=0x24, inst_in=0xFF1FF06F: next pc=0x14.
- JAL_PREDECODE_EN undefined: the same 0x1C case gives next pc=0x20 and pred_taken=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures the instruction into IF/ID, handles stall,
// EX redirect, EBREAK halt and a fetch counter. Define JAL_PREDECODE_EN for JAL predecode.
module fetch_stage #(
   parameter logic [31:0] ResetPc = 32'h0000_0000,
   parameter logic [31:0] NopInst = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_target_i,
   input  logic        resume_i,
   input  logic [31:0] inst_i,
   output logic [31:0] instruct_address_o,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] if_id_inst_o,
   output logic        if_id_valid_o,
   output logic        if_id_pred_taken_o,
   output logic        halted_o,
   output logic [31:0] fetch_count_o
);

   typedef enum logic {StRun, StHalt} state_e;

   localparam logic [31:0] Ebreak = 32'h0010_0073;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] if_id_pc_q;
   logic [31:0] if_id_inst_q;
   logic        if_id_valid_q;
   logic        if_id_pred_q;
   logic [31:0] fetch_count_q;
   logic        is_jal;
   logic [31:0] jal_target;
   logic [31:0] redirect_pc;

`ifdef JAL_PREDECODE_EN
   logic [31:0] imm_j;
   assign imm_j      = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
   assign is_jal     = (inst_i[6:0] == 7'b1101111);
   assign jal_target = pc_q + imm_j;
`else
   assign is_jal     = 1'b0;
   assign jal_target = pc_q + 32'd4;
`endif

   assign redirect_pc = {redirect_target_i[31:2], 2'b00};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StRun;
         pc_q          <= ResetPc;
         if_id_pc_q    <= ResetPc;
         if_id_inst_q  <= NopInst;
         if_id_valid_q <= 1'b0;
         if_id_pred_q  <= 1'b0;
         fetch_count_q <= 32'd0;
      end else begin
         case (state_q)
            StRun: begin
               if (redirect_valid_i) begin
                  pc_q          <= redirect_pc;
                  if_id_pc_q    <= pc_q;
                  if_id_inst_q  <= NopInst;
                  if_id_valid_q <= 1'b0;
                  if_id_pred_q  <= 1'b0;
               end else if (!stall_i) begin
                  if_id_pc_q    <= pc_q;
                  if_id_inst_q  <= inst_i;
                  if_id_valid_q <= 1'b1;
                  fetch_count_q <= fetch_count_q + 32'd1;
                  if (inst_i == Ebreak) begin
                     pc_q         <= pc_q + 32'd4;
                     if_id_pred_q <= 1'b0;
                     state_q      <= StHalt;
                  end else if (is_jal) begin
                     pc_q         <= jal_target;
                     if_id_pred_q <= 1'b1;
                  end else begin
                     pc_q         <= pc_q + 32'd4;
                     if_id_pred_q <= 1'b0;
                  end
               end
            end
            StHalt: begin
               // PC frozen; IF/ID drains to bubbles until resume or redirect.
               if_id_pc_q    <= pc_q;
               if_id_inst_q  <= NopInst;
               if_id_valid_q <= 1'b0;
               if_id_pred_q  <= 1'b0;
               if (redirect_valid_i) begin
                  pc_q    <= redirect_pc;
                  state_q <= StRun;
               end else if (resume_i) begin
                  state_q <= StRun;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

   assign instruct_address_o = pc_q;
   assign if_id_pc_o         = if_id_pc_q;
   assign if_id_inst_o       = if_id_inst_q;
   assign if_id_valid_o      = if_id_valid_q;
   assign if_id_pred_taken_o = if_id_pred_q;
   assign halted_o           = (state_q == StHalt);
   assign fetch_count_o      = fetch_count_q;

endmodule
